// File: rtl/posit32_decode_arbiter_pkg.sv
// Shared posit types: raw 32-bit posit, sign encoding and the decoded field bundle.
package posit_types;

  typedef logic [31:0] posit32_t;

  typedef enum logic {
    SIGN_POS = 1'b0,
    SIGN_NEG = 1'b1
  } sign_t;

  typedef struct packed {
    sign_t              sign;
    logic signed [31:0] regime;
    logic signed [31:0] exponent;
    logic        [31:0] fraction;
  } posit32_decoded_t;

  localparam posit32_t POSIT_ZERO = 32'h0000_0000;
  localparam posit32_t POSIT_NAR  = 32'h8000_0000;

endpackage

// File: rtl/posit32_decode.sv
// Combinational posit32 field decoder: sign, regime k, ES-bit exponent, left-aligned fraction.
module posit32_decode
  import posit_types::*;
#(
  parameter int unsigned ES = 2
) (
  input  posit32_t         i_posit,
  output posit32_decoded_t o_dec
);

  logic [30:0]        w_mag;
  logic               w_r0;
  logic [5:0]         w_run;
  logic               w_run_live;
  logic [31:0]        w_body;
  logic signed [31:0] w_run_s;

  always_comb begin
    // Negative posits decode from their two's complement magnitude.
    w_mag      = i_posit[31] ? (~i_posit[30:0] + 31'd1) : i_posit[30:0];
    w_r0       = w_mag[30];
    w_run      = '0;
    w_run_live = 1'b1;
    for (int unsigned i = 0; i < 31; i++) begin
      if (w_run_live && (w_mag[5'(30 - i)] == w_r0)) begin
        w_run = w_run + 6'd1;
      end else begin
        w_run_live = 1'b0;
      end
    end
    // Strip regime run and terminator; exponent then fraction remain MSB-aligned.
    w_body  = {w_mag, 1'b0} << (w_run + 6'd1);
    w_run_s = $signed({26'd0, w_run});

    o_dec = '0;
    if (i_posit == POSIT_ZERO) begin
      o_dec = '0;
    end else if (i_posit == POSIT_NAR) begin
      o_dec.sign = SIGN_NEG;
    end else begin
      o_dec.sign     = sign_t'(i_posit[31]);
      o_dec.regime   = w_r0 ? (w_run_s - 32'sd1) : -w_run_s;
      o_dec.exponent = $signed(w_body >> (32 - ES));
      o_dec.fraction = w_body << ES;
    end
  end

endmodule

// File: rtl/posit32_decode_arbiter_rr.sv
// Round-robin arbiter: grant search starts at the pointer, pointer moves past the winner on en.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  int unsigned      w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = (32'(r_ptr) + off) % N;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = IDX_W'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (en) begin
      r_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/posit32_decode_arbiter.sv
// Round-robin sharing of one posit32 decoder among NUM_REQ requesters, results queued in a small FIFO.
module posit32_decode_arbiter
  import posit_types::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned ES      = 2,
  parameter  int unsigned DEPTH   = 2,
  localparam int unsigned ID_W    = $clog2(NUM_REQ),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  posit32_t           req_posit [NUM_REQ],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ID_W-1:0]    out_id,
  output sign_t              out_sign,
  output logic signed [31:0] out_regime,
  output logic signed [31:0] out_exponent,
  output logic [31:0]        out_fraction,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    posit32_decoded_t dec;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_pop;
  logic               w_push;
  logic               w_can_accept;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  posit32_t           w_sel_posit;
  posit32_decoded_t   w_dec;
  entry_t             w_head;

  assign out_valid    = (r_count != '0) & ~rst;
  assign w_pop        = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_can_accept = ~rst & ((r_count < CNT_W'(DEPTH)) | w_pop);
  assign req_ready    = w_gnt & {NUM_REQ{w_can_accept}};
  assign w_push       = |req_ready;
  assign w_sel_posit  = req_posit[w_gnt_idx];

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (w_push),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  posit32_decode #(
    .ES (ES)
  ) u_dec (
    .i_posit (w_sel_posit),
    .o_dec   (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{id: w_gnt_idx, dec: w_dec};
        r_wr_ptr        <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head       = rst ? '0 : r_mem[r_rd_ptr];
  assign out_id       = w_head.id;
  assign out_sign     = w_head.dec.sign;
  assign out_regime   = w_head.dec.regime;
  assign out_exponent = w_head.dec.exponent;
  assign out_fraction = w_head.dec.fraction;
  assign occupancy    = r_count;

endmodule

// File: tb/tb_posit32_decode_arbiter.sv
// Bench for posit32_decode_arbiter: scoreboard monitor plus directed scenario tasks.
module tb_posit32_decode_arbiter;
  import posit_types::*;

  localparam int unsigned NR    = 4;
  localparam int unsigned ES    = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned IDW   = 2;
  localparam int unsigned CW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  posit32_t           req_posit [NR];
  logic               out_valid;
  logic               out_ready;
  logic [IDW-1:0]     out_id;
  sign_t              out_sign;
  logic signed [31:0] out_regime;
  logic signed [31:0] out_exponent;
  logic [31:0]        out_fraction;
  logic [CW-1:0]      occupancy;

  always #5 clk = ~clk;

  posit32_decode_arbiter #(
    .NUM_REQ (NR),
    .ES      (ES),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_posit    (req_posit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_id       (out_id),
    .out_sign     (out_sign),
    .out_regime   (out_regime),
    .out_exponent (out_exponent),
    .out_fraction (out_fraction),
    .occupancy    (occupancy)
  );

  typedef struct {
    int unsigned id;
    logic        sgn;
    int          regime;
    int          exponent;
    logic [31:0] fraction;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_count  = 0;
  int unsigned m_ptr    = 0;

  // Bit-serial reference decode of one posit32.
  function automatic exp_t ref_decode(input int unsigned id, input logic [31:0] p);
    exp_t        r;
    logic [31:0] v;
    logic        r0;
    int          i;
    int          run;
    int          pos;
    r.id = id; r.sgn = 1'b0; r.regime = 0; r.exponent = 0; r.fraction = '0;
    if (p == 32'h0000_0000) return r;
    if (p == 32'h8000_0000) begin r.sgn = 1'b1; return r; end
    r.sgn = p[31];
    v   = p[31] ? -p : p;
    r0  = v[30];
    i   = 30;
    run = 0;
    while (i >= 0 && v[i] == r0) begin run++; i--; end
    r.regime = r0 ? run - 1 : -run;
    i--;
    for (int j = 0; j < int'(ES); j++) begin
      r.exponent = r.exponent << 1;
      if (i >= 0) begin r.exponent = r.exponent | int'(v[i]); i--; end
    end
    pos = 31;
    while (i >= 0) begin r.fraction[pos] = v[i]; pos--; i--; end
    return r;
  endfunction

  // Cycle model + scoreboard, sampled on the falling edge.
  logic [NR-1:0] mon_rdy;
  logic          mon_pop;
  int            mon_g;
  int unsigned   mon_c;
  exp_t          mon_h;
  always @(negedge clk) begin
    if (rst) begin
      n_checks++;
      if (req_ready !== '0) begin
        n_fail++; $display("FAIL sb_ready_in_reset: got %b want 0000", req_ready);
      end
      sb.delete(); m_count = 0; m_ptr = 0;
    end else begin
      n_checks++;
      if (out_valid !== (m_count != 0)) begin
        n_fail++; $display("FAIL sb_out_valid: got %b want %0b", out_valid, m_count != 0);
      end
      n_checks++;
      if (occupancy !== CW'(m_count)) begin
        n_fail++; $display("FAIL sb_occupancy: got %0d want %0d", occupancy, m_count);
      end
      mon_pop = (m_count != 0) && out_ready;
      if (mon_pop && sb.size() > 0) begin
        mon_h = sb.pop_front();
        n_checks++;
        if (out_id !== IDW'(mon_h.id) || logic'(out_sign) !== mon_h.sgn ||
            out_regime !== mon_h.regime || out_exponent !== mon_h.exponent ||
            out_fraction !== mon_h.fraction) begin
          n_fail++;
          $display("FAIL sb_head: got id=%0d s=%0b k=%0d e=%0d f=%h want id=%0d s=%0b k=%0d e=%0d f=%h",
                   out_id, out_sign, out_regime, out_exponent, out_fraction,
                   mon_h.id, mon_h.sgn, mon_h.regime, mon_h.exponent, mon_h.fraction);
        end
      end
      mon_g = -1;
      for (int k = 0; k < int'(NR); k++) begin
        mon_c = (m_ptr + k) % NR;
        if (mon_g < 0 && req_valid[mon_c]) mon_g = int'(mon_c);
      end
      mon_rdy = '0;
      if (mon_g >= 0 && (m_count < DEPTH || mon_pop)) mon_rdy[mon_g] = 1'b1;
      n_checks++;
      if (req_ready !== mon_rdy) begin
        n_fail++; $display("FAIL sb_req_ready: got %b want %b", req_ready, mon_rdy);
      end
      if (mon_rdy != '0) begin
        sb.push_back(ref_decode(mon_g, req_posit[mon_g]));
        m_ptr = (mon_g + 1) % NR;
      end
      m_count = m_count + ((mon_rdy != '0) ? 1 : 0) - (mon_pop ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; out_ready = 1'b1;
    for (int r = 0; r < int'(NR); r++) req_posit[r] = 32'h4000_0000 + r;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== '0 || req_ready !== '0) begin
      n_fail++; $display("FAIL reset_state: got v=%b occ=%0d rdy=%b want 0 0 0000", out_valid, occupancy, req_ready);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    out_ready = 1'b1; req_valid = 4'b0100; req_posit[2] = 32'h4000_0000;
    e = ref_decode(2, 32'h4000_0000);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || out_sign !== SIGN_POS ||
        out_regime !== 0 || out_exponent !== 0 || out_fraction !== e.fraction) begin
      n_fail++;
      $display("FAIL single_decode: got v=%b id=%0d s=%0b k=%0d e=%0d f=%h want 1 2 0 0 0 %h",
               out_valid, out_id, out_sign, out_regime, out_exponent, out_fraction, e.fraction);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] specials [8];
    logic [NR-1:0] want;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'hC000_0000, 32'h7FFF_FFFF,
                 32'h0000_0001, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h5A5A_1234};
    do_reset();
    out_ready = 1'b1; req_valid = '1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      for (int r = 0; r < int'(NR); r++)
        req_posit[r] = (cyc < 2) ? specials[cyc * 4 + r] : $urandom;
      want = 4'b0001 << (cyc % 4);
      @(negedge clk);
      n_checks++;
      if (req_ready !== want) begin
        n_fail++; $display("FAIL rr_grant cyc=%0d: got %b want %b", cyc, req_ready, want);
      end
      if (cyc > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== IDW'((cyc - 1) % 4)) begin
          n_fail++; $display("FAIL rr_output cyc=%0d: got v=%b id=%0d want 1 %0d", cyc, out_valid, out_id, (cyc - 1) % 4);
        end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [IDW-1:0] s_id;
    logic [31:0]    s_k, s_e, s_f;
    exp_t           e3;
    do_reset();
    out_ready = 1'b0; req_valid = 4'b1010;
    req_posit[1] = 32'h6000_0000; req_posit[3] = 32'h4800_0000;
    e3 = ref_decode(3, 32'h4800_0000);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
    tick();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant3: got %b want 1000", req_ready); end
    tick();
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || occupancy !== 2'd2 || out_valid !== 1'b1 || out_id !== 2'd1) begin
      n_fail++; $display("FAIL bp_full: got rdy=%b occ=%0d v=%b id=%0d want 0000 2 1 1", req_ready, occupancy, out_valid, out_id);
    end
    s_id = out_id; s_k = out_regime; s_e = out_exponent; s_f = out_fraction;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== s_id || out_regime !== s_k || out_exponent !== s_e || out_fraction !== s_f) begin
      n_fail++; $display("FAIL bp_stable: got v=%b id=%0d k=%0d e=%0d want 1 %0d %0d %0d", out_valid, out_id, out_regime, out_exponent, s_id, s_k, s_e);
    end
    tick();
    req_valid = '0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_id !== 2'd1 || out_regime !== 1 || out_exponent !== 0) begin
      n_fail++; $display("FAIL bp_drain1: got id=%0d k=%0d e=%0d want 1 1 0", out_id, out_regime, out_exponent);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (out_id !== 2'd3 || out_regime !== 0 || out_exponent !== e3.exponent) begin
      n_fail++; $display("FAIL bp_drain3: got id=%0d k=%0d e=%0d want 3 0 %0d", out_id, out_regime, out_exponent, e3.exponent);
    end
    tick();
  endtask

  task automatic test_full_pop_push();
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0011;
    req_posit[0] = 32'h5000_0000; req_posit[1] = 32'h5800_0000; req_posit[2] = 32'h4400_0000;
    tick(); tick();
    out_ready = 1'b1; req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100 || occupancy !== 2'd2 || out_id !== 2'd0) begin
      n_fail++; $display("FAIL full_pushpop: got rdy=%b occ=%0d id=%0d want 0100 2 0", req_ready, occupancy, out_id);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== 2'd2 || out_id !== 2'd1) begin
      n_fail++; $display("FAIL full_after: got occ=%0d id=%0d want 2 1", occupancy, out_id);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (occupancy !== 2'd1 || out_id !== 2'd2) begin
      n_fail++; $display("FAIL full_order: got occ=%0d id=%0d want 1 2", occupancy, out_id);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0110;
    req_posit[1] = 32'h6400_0000; req_posit[2] = 32'h3000_0000; req_posit[3] = 32'hB000_0000;
    tick(); tick();
    req_valid = 4'b1010; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_during: got rdy=%b v=%b want 0000 0", req_ready, out_valid);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== '0 || req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL midrst_after: got v=%b occ=%0d rdy=%b want 0 0 0010", out_valid, occupancy, req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1) begin
      n_fail++; $display("FAIL midrst_regrant: got v=%b id=%0d want 1 1", out_valid, out_id);
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    for (int r = 0; r < int'(NR); r++) req_posit[r] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_pop_push();
    test_reset_mid();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drained: got %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
